// File: rtl/tof_readout_scheduler.sv
// tof_readout_scheduler: round-robin ToF sensor readout with settle delay and FWFT output FIFO
module tof_readout_scheduler #(
  parameter int FIFO_DEPTH    = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ready_in,
  input  logic [21:0] data_in,
  input  logic [7:0]  enable_mask,
  output logic [2:0]  tof_index,
  output logic        out_valid,
  output logic [24:0] out_data,
  input  logic        out_ready,
  output logic [4:0]  fifo_level,
  output logic [7:0]  drop_count,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {SCAN, SETTLE, CAPTURE} state_t;
  state_t        state;
  logic [7:0]    pending, req, clr;
  logic [2:0]    grant, last_grant, pick;
  logic [3:0]    cnt;
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          cap, full, pop, push;
  assign req        = pending & enable_mask;
  assign cap        = state == CAPTURE;
  assign full       = fifo_level == 5'(FIFO_DEPTH);
  assign out_valid  = fifo_level != 5'd0;
  assign pop        = out_valid & out_ready;
  assign push       = cap & (~full | pop);
  assign clr        = cap ? 8'b1 << grant : 8'b0;
  assign busy       = state != SCAN;
  assign out_data   = mem[rd_ptr];
  // Walk downward so the nearest requester after last_grant is the final assignment.
  always_comb begin
    pick = last_grant;
    for (int k = 7; k >= 0; k--)
      if (req[3'(last_grant + 3'(k) + 3'd1)]) pick = 3'(last_grant + 3'(k) + 3'd1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      pending    <= '0;
      grant      <= '0;
      last_grant <= 3'd7;
      tof_index  <= '0;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
    end else begin
      pending <= ready_in | (pending & ~clr);
      if (state == SCAN && req != 8'd0) begin
        grant     <= pick;
        tof_index <= pick;
        cnt       <= '0;
        state     <= SETTLE;
      end else if (state == SETTLE) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'(SETTLE_CYCLES - 1)) state <= CAPTURE;
      end else if (cap) begin
        last_grant <= grant;
        state      <= SCAN;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + 5'(push) - 5'(pop);
      if (cap & full & ~pop & (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {grant, data_in};
endmodule

// File: tb/tb_tof_readout_scheduler.sv
// tb_tof_readout_scheduler: directed and randomized checks against a queue-based behavioural model
module tb_tof_readout_scheduler;
  localparam int DEPTH  = 8;
  localparam int SETTLE = 1;
  logic        clk = 0;
  logic        reset = 0;
  logic [7:0]  ready_in = 0;
  logic [21:0] data_in = 0;
  logic [7:0]  enable_mask = 8'hFF;
  logic        out_ready = 0;
  logic [2:0]  tof_index;
  logic        out_valid;
  logic [24:0] out_data;
  logic [4:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        busy;
  int n_assert = 0;
  int n_fail = 0;

  tof_readout_scheduler #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .ready_in(ready_in), .data_in(data_in),
    .enable_mask(enable_mask), .tof_index(tof_index), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .fifo_level(fifo_level),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending flags, countdown of edges left in the current grant, and a queue for the FIFO.
  bit [7:0]    m_pend = 0;
  int          m_left = 0;
  bit [2:0]    m_grant = 0, m_last = 7, m_tof = 0;
  logic [24:0] q [$];
  int          m_drop = 0;
  bit          m_pop, m_cap, m_found;
  bit [7:0]    m_req, m_clr;
  bit [2:0]    m_idx;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 0; m_left = 0; m_grant = 0; m_last = 7; m_tof = 0; m_drop = 0;
      q.delete();
    end else begin
      m_pop = q.size() > 0 && out_ready;
      m_cap = 0;
      m_clr = 0;
      if (m_left == 0) begin
        m_req = m_pend & enable_mask;
        m_found = 0;
        for (int k = 1; k <= 8; k++) begin
          m_idx = 3'((int'(m_last) + k) % 8);
          if (!m_found && m_req[m_idx]) begin
            m_found = 1; m_grant = m_idx; m_tof = m_idx;
          end
        end
        if (m_found) m_left = SETTLE + 1;
      end else if (m_left > 1) begin
        m_left--;
      end else begin
        m_cap = 1; m_left = 0; m_clr[m_grant] = 1; m_last = m_grant;
      end
      if (m_pop) void'(q.pop_front());
      if (m_cap) begin
        if (q.size() < DEPTH) q.push_back({m_grant, data_in});
        else if (m_drop < 255) m_drop++;
      end
      m_pend = ready_in | (m_pend & ~m_clr);
    end
  end

  always @(negedge clk) begin
    chk("tof_index", 32'(tof_index), 32'(m_tof));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    ready_in = 0; out_ready = 0; enable_mask = 8'hFF;
    reset = 0;
    tick; tick;
    chk("rst tof_index", 32'(tof_index), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst fifo_level", 32'(fifo_level), 0);
    chk("rst drop_count", 32'(drop_count), 0);
    chk("rst busy", 32'(busy), 0);
    reset = 1;
  endtask

  task automatic grant_seq(input string nm, input logic [11:0] exp);
    int got = 0;
    logic pb = busy;
    for (int t = 0; t < 60 && got < 4; t++) begin
      tick;
      if (busy && !pb) begin
        chk(nm, 32'(tof_index), 32'(exp[got*3 +: 3]));
        got++;
      end
      pb = busy;
    end
    chk({nm, " grants seen"}, 32'(got), 4);
  endtask

  initial begin
    tick;
    // single request
    do_reset;
    data_in = 22'h0A1234;
    tick; ready_in = 8'h04;
    tick; ready_in = 0;
    tick;
    chk("single tof_index", 32'(tof_index), 2);
    chk("single busy", 32'(busy), 1);
    tick;
    chk("single early valid", 32'(out_valid), 0);
    tick;
    chk("single valid", 32'(out_valid), 1);
    chk("single data", 32'(out_data), 32'({3'd2, 6'h0A, 16'h1234}));
    out_ready = 1;
    tick; out_ready = 0;
    chk("single drained", 32'(fifo_level), 0);
    // round robin
    do_reset;
    out_ready = 1; ready_in = 8'h81;
    grant_seq("rr order", {3'd7, 3'd0, 3'd7, 3'd0});
    // mask
    do_reset;
    out_ready = 1; ready_in = 8'h0F; enable_mask = 8'h0A;
    grant_seq("mask order", {3'd3, 3'd1, 3'd3, 3'd1});
    // overflow
    do_reset;
    ready_in = 8'hFF;
    begin
      int t = 0;
      while (drop_count != 8'd2 && t < 100) begin tick; t++; end
    end
    enable_mask = 0; ready_in = 0;
    tick;
    chk("ovf level", 32'(fifo_level), 8);
    chk("ovf drops", 32'(drop_count), 2);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf drain order", 32'(out_data[24:22]), 32'(i));
      tick;
    end
    chk("ovf empty", 32'(fifo_level), 0);
    // collision: ready pulses on the capture edge
    do_reset;
    ready_in = 8'h01;
    tick; ready_in = 0;
    tick; tick; ready_in = 8'h01;
    tick; ready_in = 0;
    chk("coll gap busy", 32'(busy), 0);
    chk("coll level", 32'(fifo_level), 1);
    tick;
    chk("coll regrant busy", 32'(busy), 1);
    chk("coll regrant tof", 32'(tof_index), 0);
    tick; tick;
    chk("coll level2", 32'(fifo_level), 2);
    // reset mid-settle
    do_reset;
    ready_in = 8'h10;
    tick; ready_in = 0;
    tick;
    chk("mid busy", 32'(busy), 1);
    chk("mid tof", 32'(tof_index), 4);
    reset = 0;
    tick;
    chk("mid rst tof", 32'(tof_index), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst valid", 32'(out_valid), 0);
    chk("mid rst drops", 32'(drop_count), 0);
    reset = 1;
    tick; tick; tick;
    chk("mid no push", 32'(fifo_level), 0);
    // randomized
    do_reset;
    for (int t = 0; t < 3000; t++) begin
      ready_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 15) == 0) enable_mask = 8'($urandom);
      out_ready = ((t / 400) % 2 == 1) ? ($urandom_range(0, 7) == 0) : 1'($urandom);
      data_in = 22'($urandom);
      reset = ($urandom_range(0, 499) != 0);
      tick;
    end
    reset = 1;
    // drop counter saturation
    do_reset;
    ready_in = 8'hFF;
    repeat (850) tick;
    chk("drop saturate", 32'(drop_count), 255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
